csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port timer_int_i, input, 1, machine timer pending level.
REQ-004 SHALL have port id_csr_raddr_i, input, 12, CSR read address from decode.
REQ-005 SHALL have port id_csr_rdata_o, output, 32, combinational read data to decode.
REQ-006 SHALL have ports ex_csr_we_i/ex_csr_waddr_i/ex_csr_wdata_i, input, 1/12/32, CSR-instruction write port.
REQ-007 SHALL have ports cl_csr_we_i/cl_csr_waddr_i/cl_csr_wdata_i, input, 1/12/32, trap-controller write port.
REQ-008 SHALL have ports mstatus_o/mtvec_o/mepc_o, output, 32 each, current register contents to the trap controller.

Function
REQ-009 SHALL implement these CSRs:
- mstatus 0x300
- misa 0x301
- mie 0x304
- mtvec 0x305
- mscratch 0x340
- mepc 0x341
- mcause 0x342
- mtval 0x343
- mip 0x344
- mcycle 0xB00
- mcycleh 0xB80
- mhartid 0xF14
REQ-010 SHALL commit writes on the rising edge after the write enable is sampled high; write latency is one cycle.
REQ-011 SHALL apply both ports in the same cycle when they target different addresses.
REQ-012 SHALL, when both ports target the same address in the same cycle, give the cl port priority and drop the ex write.
REQ-013 SHALL make id_csr_rdata_o forward the in-flight write data when id_csr_raddr_i matches an enabled write address this cycle.
- cl port data takes priority over ex port data.
- Without a match, the stored value is returned.
REQ-014 SHALL drive mstatus_o, mtvec_o and mepc_o from the stored registers with no forwarding, so a write is visible the cycle after commit.
REQ-015 SHALL make mstatus writable only at MIE[3] and MPIE[7], with MPP[12:11] hardwired to 2'b11 and all other bits reading 0.
REQ-016 SHALL make mie writable only at bits 3, 7 and 11, all other bits reading 0.
REQ-017 SHALL make mip read {24'd0, timer_int_i, 7'd0}, with writes ignored.
REQ-018 SHALL force mepc bits [1:0] to 0 on write.
REQ-019 SHALL store mtvec, mscratch, mcause and mtval as full 32-bit registers.
REQ-020 SHALL make misa read constant 0x40000100 and mhartid read constant 0, with writes ignored.
REQ-021 SHALL make any unimplemented address read 0 and ignore writes to it; no exception is raised.

Reset
REQ-022 SHALL, while rst_n is low at a clock edge, load:
- mstatus 0x00001800
- all other writable registers 0
- mcycle/mcycleh 0
REQ-023 SHALL drop any write presented in a cycle where rst_n is low.
REQ-024 SHALL make outputs reflect reset values from the first edge after reset is asserted, with mstatus_o = 0x00001800.

Configuration
REQ-025 SHALL include the cycle counter only when macro CSR_CYCLE_COUNTER_EN is defined.
REQ-026 SHALL, with CSR_CYCLE_COUNTER_EN defined, operate {mcycleh, mcycle} as a 64-bit counter incrementing every non-reset cycle.
- Carry passes into mcycleh when mcycle = 0xFFFFFFFF.
- The counter wraps from all-ones to 0.
- A write to mcycle replaces that cycle's increment of mcycle; mcycleh still takes any carry.
- A write to mcycleh replaces mcycleh only; mcycle still increments.
REQ-027 SHALL, without CSR_CYCLE_COUNTER_EN, make 0xB00 and 0xB80 behave as unimplemented addresses (read 0, writes ignored) and synthesize no counter flops.

Verification
REQ-028 SHALL pass: reset, then read 0x300 -> rdata 0x00001800; mstatus_o 0x00001800.
REQ-029 SHALL pass: ex writes 0x341 data 0x8000_0107, with id reading 0x341 the same cycle -> rdata 0x8000_0107 same cycle; mepc_o 0x8000_0104 next cycle.
REQ-030 SHALL pass: ex writes 0x342 = 0x5 and cl writes 0x342 = 0x8 in the same cycle -> mcause reads 0x8.
REQ-031 SHALL pass: cl writes 0x300 = 0xFFFFFFFF -> mstatus_o 0x00001888; then write 0 -> 0x00001800.
REQ-032 SHALL pass: timer_int_i = 1, read 0x344 -> 0x80; write 0x344 = 0 -> still 0x80; timer_int_i = 0 -> 0x0.
REQ-033 SHALL pass, with CSR_CYCLE_COUNTER_EN defined: ex writes 0xB00 = 0xFFFFFFFE -> mcycle 0xFFFFFFFE next cycle, then 0xFFFFFFFF, then 0 with mcycleh 1; without the macro, reads of 0xB00 return 0.

Source files
------------

// File: rtl/csr_file_if.sv
// CSR bus between the pipeline (decode read port, EX and trap-controller write ports)
// and the machine-mode CSR file; the pipeline side is the master.
`timescale 1ns/1ps
interface csr_file_if;
  logic [11:0] id_csr_raddr_i;
  logic [31:0] id_csr_rdata_o;
  logic        ex_csr_we_i;
  logic [11:0] ex_csr_waddr_i;
  logic [31:0] ex_csr_wdata_i;
  logic        cl_csr_we_i;
  logic [11:0] cl_csr_waddr_i;
  logic [31:0] cl_csr_wdata_i;
  logic [31:0] mstatus_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;

  modport master (
    output id_csr_raddr_i, ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
           cl_csr_we_i, cl_csr_waddr_i, cl_csr_wdata_i,
    input  id_csr_rdata_o, mstatus_o, mtvec_o, mepc_o
  );

  modport slave (
    input  id_csr_raddr_i, ex_csr_we_i, ex_csr_waddr_i, ex_csr_wdata_i,
           cl_csr_we_i, cl_csr_waddr_i, cl_csr_wdata_i,
    output id_csr_rdata_o, mstatus_o, mtvec_o, mepc_o
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: two write ports (EX, trap controller) and a forwarding read port.
// Define CSR_CYCLE_COUNTER_EN to add the 64-bit {mcycleh, mcycle} counter.
`timescale 1ns/1ps
module csr_file (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      timer_int_i,
  csr_file_if.slave bus
);
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MISA_VAL      = 32'h4000_0100;

  logic [31:0] mstatus_q,  mstatus_d;
  logic [31:0] mie_q,      mie_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;
  logic [31:0] mtval_q,    mtval_d;
`ifdef CSR_CYCLE_COUNTER_EN
  logic [31:0] mcycle_q,   mcycle_d;
  logic [31:0] mcycleh_q,  mcycleh_d;
`endif

  logic [1:0]       wr_en;
  logic [1:0][11:0] wr_addr;
  logic [1:0][31:0] wr_data;
  logic [31:0]      stored_rdata;
  logic [31:0]      rdata;

  // Index 1 is the trap controller; it is applied last so it overrides EX on the same CSR.
  always_comb begin
    wr_en   = {bus.cl_csr_we_i,    bus.ex_csr_we_i};
    wr_addr = {bus.cl_csr_waddr_i, bus.ex_csr_waddr_i};
    wr_data = {bus.cl_csr_wdata_i, bus.ex_csr_wdata_i};
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
`ifdef CSR_CYCLE_COUNTER_EN
    mcycle_d   = mcycle_q + 32'd1;
    mcycleh_d  = mcycleh_q + {31'd0, &mcycle_q};
`endif
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        case (wr_addr[p])
          ADDR_MSTATUS:  mstatus_d  = MSTATUS_RST | (wr_data[p] & MSTATUS_WMASK);
          ADDR_MIE:      mie_d      = wr_data[p] & MIE_WMASK;
          ADDR_MTVEC:    mtvec_d    = wr_data[p];
          ADDR_MSCRATCH: mscratch_d = wr_data[p];
          ADDR_MEPC:     mepc_d     = {wr_data[p][31:2], 2'b00};
          ADDR_MCAUSE:   mcause_d   = wr_data[p];
          ADDR_MTVAL:    mtval_d    = wr_data[p];
`ifdef CSR_CYCLE_COUNTER_EN
          ADDR_MCYCLE:   mcycle_d   = wr_data[p];
          ADDR_MCYCLEH:  mcycleh_d  = wr_data[p];
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef CSR_CYCLE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q  <= '0;
      mcycleh_q <= '0;
    end else begin
      mcycle_q  <= mcycle_d;
      mcycleh_q <= mcycleh_d;
    end
  end
`endif

  always_comb begin
    stored_rdata = '0;
    case (bus.id_csr_raddr_i)
      ADDR_MSTATUS:  stored_rdata = mstatus_q;
      ADDR_MISA:     stored_rdata = MISA_VAL;
      ADDR_MIE:      stored_rdata = mie_q;
      ADDR_MTVEC:    stored_rdata = mtvec_q;
      ADDR_MSCRATCH: stored_rdata = mscratch_q;
      ADDR_MEPC:     stored_rdata = mepc_q;
      ADDR_MCAUSE:   stored_rdata = mcause_q;
      ADDR_MTVAL:    stored_rdata = mtval_q;
      ADDR_MIP:      stored_rdata = {24'd0, timer_int_i, 7'd0};
`ifdef CSR_CYCLE_COUNTER_EN
      ADDR_MCYCLE:   stored_rdata = mcycle_q;
      ADDR_MCYCLEH:  stored_rdata = mcycleh_q;
`endif
      ADDR_MHARTID:  stored_rdata = '0;
      default:       stored_rdata = '0;
    endcase
  end

  // Forwarding returns the raw in-flight data, before any write masking.
  always_comb begin
    rdata = stored_rdata;
    if (bus.cl_csr_we_i && (bus.cl_csr_waddr_i == bus.id_csr_raddr_i)) begin
      rdata = bus.cl_csr_wdata_i;
    end else if (bus.ex_csr_we_i && (bus.ex_csr_waddr_i == bus.id_csr_raddr_i)) begin
      rdata = bus.ex_csr_wdata_i;
    end
  end

  assign bus.id_csr_rdata_o = rdata;
  assign bus.mstatus_o      = mstatus_q;
  assign bus.mtvec_o        = mtvec_q;
  assign bus.mepc_o         = mepc_q;
endmodule

// File: tb/tb_csr_file.sv
// Scoreboard testbench for csr_file: directed scenarios then randomized traffic,
// all checked against a behavioural CSR model.
`timescale 1ns/1ps
module tb_csr_file;
  logic clk;
  logic rst_n;
  logic timer_int_i;

  csr_file_if bus ();

  csr_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .timer_int_i (timer_int_i),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CSR_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  bit [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  bit [63:0] m_cycle;
  bit [63:0] nxt_cycle;

  bit [11:0] addr_pool [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hF14,
                                12'h123, 12'h7FF};

  // Architectural view of each CSR as software would read it.
  function automatic bit [31:0] model_stored(input bit [11:0] a, input bit timer);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return timer ? 32'h0000_0080 : 32'h0;
      12'hB00: return CNT_EN ? m_cycle[31:0] : 32'h0;
      12'hB80: return CNT_EN ? m_cycle[63:32] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mstatus  = 32'h0000_1800;
    m_mie      = 0;
    m_mtvec    = 0;
    m_mscratch = 0;
    m_mepc     = 0;
    m_mcause   = 0;
    m_mtval    = 0;
    m_cycle    = 0;
  endtask

  task automatic model_write(input bit [11:0] a, input bit [31:0] d);
    case (a)
      12'h300: m_mstatus  = 32'h0000_1800 | (d & 32'h0000_0088);
      12'h304: m_mie      = d & 32'h0000_0888;
      12'h305: m_mtvec    = d;
      12'h340: m_mscratch = d;
      12'h341: m_mepc     = d & 32'hFFFF_FFFC;
      12'h342: m_mcause   = d;
      12'h343: m_mtval    = d;
      12'hB00: if (CNT_EN) nxt_cycle[31:0]  = d;
      12'hB80: if (CNT_EN) nxt_cycle[63:32] = d;
      default: ;
    endcase
  endtask

  task automatic model_commit(input bit rst, input bit exwe, input bit [11:0] exa,
                              input bit [31:0] exd, input bit clwe, input bit [11:0] cla,
                              input bit [31:0] cld);
    if (!rst) begin
      model_reset();
    end else begin
      nxt_cycle = m_cycle + 64'd1;
      if (exwe && !(clwe && (cla == exa))) model_write(exa, exd);
      if (clwe) model_write(cla, cld);
      m_cycle = nxt_cycle;
    end
  endtask

  task automatic checkOutput(input string name, input logic [11:0] raddr,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s raddr=%h actual=%h required=%h", name, raddr, act, exp);
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation, mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checkOutput("rdata",     mon_e.raddr, bus.id_csr_rdata_o, mon_e.rdata);
      checkOutput("mstatus_o", mon_e.raddr, bus.mstatus_o,      mon_e.mstatus);
      checkOutput("mtvec_o",   mon_e.raddr, bus.mtvec_o,        mon_e.mtvec);
      checkOutput("mepc_o",    mon_e.raddr, bus.mepc_o,         mon_e.mepc);
    end
  end

  // Drives one cycle of stimulus, queues the expected response, then commits the model.
  task automatic applyStimulus(input bit rst, input bit timer, input bit [11:0] raddr,
                               input bit exwe, input bit [11:0] exa, input bit [31:0] exd,
                               input bit clwe, input bit [11:0] cla, input bit [31:0] cld);
    exp_t e;
    rst_n              = rst;
    timer_int_i        = timer;
    bus.id_csr_raddr_i = raddr;
    bus.ex_csr_we_i    = exwe;
    bus.ex_csr_waddr_i = exa;
    bus.ex_csr_wdata_i = exd;
    bus.cl_csr_we_i    = clwe;
    bus.cl_csr_waddr_i = cla;
    bus.cl_csr_wdata_i = cld;
    e.raddr = raddr;
    if (clwe && (cla == raddr))      e.rdata = cld;
    else if (exwe && (exa == raddr)) e.rdata = exd;
    else                             e.rdata = model_stored(raddr, timer);
    e.mstatus = m_mstatus;
    e.mtvec   = m_mtvec;
    e.mepc    = m_mepc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    model_commit(rst, exwe, exa, exd, clwe, cla, cld);
  endtask

  task automatic idleRead(input bit timer, input bit [11:0] raddr);
    applyStimulus(1'b1, timer, raddr, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [11:0] ra, ea, ca;
    bit        ew, cw, tm, rs;

    rst_n              = 1'b0;
    timer_int_i        = 1'b0;
    bus.id_csr_raddr_i = 12'h300;
    bus.ex_csr_we_i    = 1'b0;
    bus.ex_csr_waddr_i = 12'h0;
    bus.ex_csr_wdata_i = 32'h0;
    bus.cl_csr_we_i    = 1'b0;
    bus.cl_csr_waddr_i = 12'h0;
    bus.cl_csr_wdata_i = 32'h0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset values; a write during reset must be dropped.
    applyStimulus(1'b0, 1'b0, 12'h300, 1'b1, 12'h305, 32'hDEAD_BEEF, 1'b0, 12'h0, 32'h0);
    idleRead(1'b0, 12'h300);
    idleRead(1'b0, 12'h305);

    // mepc forwarding and masking.
    applyStimulus(1'b1, 1'b0, 12'h341, 1'b1, 12'h341, 32'h8000_0107, 1'b0, 12'h0, 32'h0);
    idleRead(1'b0, 12'h341);

    // Same-address collision: trap controller wins.
    applyStimulus(1'b1, 1'b0, 12'h342, 1'b1, 12'h342, 32'h5, 1'b1, 12'h342, 32'h8);
    idleRead(1'b0, 12'h342);

    // Different addresses both commit.
    applyStimulus(1'b1, 1'b0, 12'h340, 1'b1, 12'h305, 32'h1234_5678, 1'b1, 12'h340, 32'hCAFE_F00D);
    idleRead(1'b0, 12'h305);
    idleRead(1'b0, 12'h340);

    // mstatus write mask.
    applyStimulus(1'b1, 1'b0, 12'h301, 1'b0, 12'h0, 32'h0, 1'b1, 12'h300, 32'hFFFF_FFFF);
    idleRead(1'b0, 12'h300);
    applyStimulus(1'b1, 1'b0, 12'h304, 1'b0, 12'h0, 32'h0, 1'b1, 12'h300, 32'h0);
    idleRead(1'b0, 12'h300);

    // mie mask, mip from the timer input, constant and unimplemented CSRs.
    applyStimulus(1'b1, 1'b0, 12'hF14, 1'b1, 12'h304, 32'hFFFF_FFFF, 1'b0, 12'h0, 32'h0);
    idleRead(1'b0, 12'h304);
    idleRead(1'b1, 12'h344);
    applyStimulus(1'b1, 1'b1, 12'h301, 1'b1, 12'h344, 32'h0, 1'b0, 12'h0, 32'h0);
    idleRead(1'b1, 12'h344);
    idleRead(1'b0, 12'h344);
    applyStimulus(1'b1, 1'b0, 12'h301, 1'b1, 12'h123, 32'hFFFF_FFFF, 1'b1, 12'hF14, 32'h55);
    idleRead(1'b0, 12'h123);
    idleRead(1'b0, 12'hF14);

    // Cycle counter carry into mcycleh (reads 0 when the counter is absent).
    applyStimulus(1'b1, 1'b0, 12'h300, 1'b1, 12'hB00, 32'hFFFF_FFFE, 1'b0, 12'h0, 32'h0);
    idleRead(1'b0, 12'hB00);
    idleRead(1'b0, 12'hB00);
    idleRead(1'b0, 12'hB00);
    idleRead(1'b0, 12'hB80);
    applyStimulus(1'b1, 1'b0, 12'hB00, 1'b1, 12'hB80, 32'hFFFF_FFFF, 1'b0, 12'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 12'hB80, 1'b0, 12'h0, 32'h0, 1'b1, 12'hB00, 32'hFFFF_FFFF);
    idleRead(1'b0, 12'hB80);
    idleRead(1'b0, 12'hB00);

    // Randomized traffic with occasional resets and frequent address collisions.
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(49, 0) != 0);
      tm = $urandom_range(1, 0) == 1;
      ra = addr_pool[$urandom_range(13, 0)];
      ew = $urandom_range(2, 0) != 0;
      cw = $urandom_range(2, 0) == 0;
      ea = addr_pool[$urandom_range(13, 0)];
      ca = ($urandom_range(3, 0) == 0) ? ea : addr_pool[$urandom_range(13, 0)];
      if ($urandom_range(3, 0) == 0) ra = ea;
      applyStimulus(rs, tm, ra, ew, ea, $urandom, cw, ca, $urandom);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
